// File: rtl/result_tx_reader_pkg.sv
// Shared constants, types and header helpers for the result transmit reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package result_tx_reader_pkg;

    localparam int PKT_LEN   = 1257;  // payload bytes per row
    localparam int ROWS      = 696;   // rows per frame
    localparam int ADDR_W    = 13;    // result RAM address width
    localparam int ROW_IDX_W = 15;    // row index carried in the header
    localparam int SOF_BIT   = 7;     // start-of-frame flag position in header byte 0
    localparam int CNT_W     = 11;    // payload read counter width
    localparam int SKID_W    = 10;    // sop + eop + data byte

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HDR0       = 3'd1,
        HDR1       = 3'd2,
        PAYLOAD    = 3'd3,
        WAIT_DRAIN = 3'd4
    } state_t;

    // One entry of the output skid buffer: framing tags travel with the byte.
    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] dat;
    } tx_word_t;

    // Header byte 0: start-of-frame flag (row 0) above the row index MSBs.
    function automatic logic [7:0] hdr0_byte(input logic [ROW_IDX_W-1:0] row);
        logic [7:0] b;
        b          = {1'b0, row[ROW_IDX_W-1:8]};
        b[SOF_BIT] = (row == '0);
        return b;
    endfunction

endpackage

// File: rtl/tx_skid_buf.sv
// Two-entry valid/ready buffer; the head entry drives the output directly.
// Latency: 1 cycle from in_vld to out_vld when empty.
// Backpressure: holds up to 2 words stable while out_rdy is low; caller keeps pushes within free space.
module tx_skid_buf #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy,
    output logic [1:0]   occupancy
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   cnt_q;
    logic         pop;

    assign pop       = out_vld && out_rdy;
    assign out_vld   = (cnt_q != 2'd0);
    assign out_dat   = head_q;
    assign occupancy = cnt_q;

    // Head/tail shuffle: head always holds the oldest word, tail the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            if (in_vld && !pop) begin
                if (cnt_q == 2'd0) head_q <= in_dat;
                else               tail_q <= in_dat;
                cnt_q <= cnt_q + 2'd1;
            end else if (pop && !in_vld) begin
                if (cnt_q == 2'd2) head_q <= tail_q;
                cnt_q <= cnt_q - 2'd1;
            end else if (pop && in_vld) begin
                if (cnt_q == 2'd1) begin
                    head_q <= in_dat;
                end else begin
                    head_q <= tail_q;
                    tail_q <= in_dat;
                end
            end
        end
    end

endmodule

// File: rtl/result_tx_reader.sv
// Drains completed result rows and emits each as a framed byte stream (2-byte header + row).
// Latency: 2 cycles from pkt_ready in IDLE to tx_sop; 1 byte/cycle when tx_ready stays high.
// Backpressure: reads/header pushes only when the 2-entry skid buffer has room after in-flight reads land.
module result_tx_reader #(
    parameter int PKT_LEN = result_tx_reader_pkg::PKT_LEN,
    parameter int ROWS    = result_tx_reader_pkg::ROWS,
    parameter int ADDR_W  = result_tx_reader_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              rd_row_data_done,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_sop,
    output logic              tx_eop,
    input  logic              tx_ready
);
    import result_tx_reader_pkg::*;

    state_t                 state_q, state_d;
    logic [ROW_IDX_W-1:0]   row_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   rd_vld_q;     // read issued last cycle, data on rd_data now
    logic                   rd_eop_q;     // that read was the last payload byte
    logic [1:0]             occ;
    logic                   pop;
    logic [2:0]             held;         // bytes still owed to the buffer after this cycle's pop
    logic                   last_rd;
    logic                   hdr_push;
    tx_word_t               hdr_word;
    tx_word_t               skid_in;
    tx_word_t               skid_out;

    assign pop              = tx_valid && tx_ready;
    assign held             = {1'b0, occ} - {2'b00, pop} + {2'b00, rd_vld_q};
    assign last_rd          = (cnt_q == CNT_W'(PKT_LEN - 1));
    assign rd_addr          = addr_q;
    assign rd_row_data_done = (state_q == WAIT_DRAIN) && pop && skid_out.eop;

    assign skid_in = rd_vld_q ? tx_word_t'{sop: 1'b0, eop: rd_eop_q, dat: rd_data} : hdr_word;
    assign tx_sop  = skid_out.sop;
    assign tx_eop  = skid_out.eop;
    assign tx_data = skid_out.dat;

    tx_skid_buf #(.W(SKID_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (hdr_push || rd_vld_q),
        .in_dat    (skid_in),
        .out_vld   (tx_valid),
        .out_dat   (skid_out),
        .out_rdy   (tx_ready),
        .occupancy (occ)
    );

    // Next-state, header pushes and read issue; HDR1 may also launch the first read when two slots are free.
    always_comb begin
        state_d  = state_q;
        hdr_push = 1'b0;
        hdr_word = '0;
        rd_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pkt_ready) state_d = HDR0;
            end
            HDR0: begin
                if (held < 3'd2) begin
                    hdr_push = 1'b1;
                    hdr_word = tx_word_t'{sop: 1'b1, eop: 1'b0, dat: hdr0_byte(row_q)};
                    state_d  = HDR1;
                end
            end
            HDR1: begin
                if (held < 3'd2) begin
                    hdr_push = 1'b1;
                    hdr_word = tx_word_t'{sop: 1'b0, eop: 1'b0, dat: row_q[7:0]};
                    state_d  = PAYLOAD;
                    if (held == 3'd0) begin
                        rd_en = 1'b1;
                        if (last_rd) state_d = WAIT_DRAIN;
                    end
                end
            end
            PAYLOAD: begin
                if (held < 3'd2) begin
                    rd_en = 1'b1;
                    if (last_rd) state_d = WAIT_DRAIN;
                end
            end
            WAIT_DRAIN: begin
                if (rd_row_data_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, address, payload counter, in-flight read tracking and row index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_eop_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_en;
            rd_eop_q <= rd_en && last_rd;
            if (state_q == HDR0) begin
                cnt_q <= '0;
            end else if (rd_en) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Address free-runs with the buffer's write pointer and wraps at the RAM depth.
            if (rd_en) addr_q <= addr_q + ADDR_W'(1);
            if (rd_row_data_done) begin
                if (row_q == ROW_IDX_W'(ROWS - 1)) row_q <= '0;
                else                              row_q <= row_q + ROW_IDX_W'(1);
            end
        end
    end

endmodule

// File: doc/result_tx_reader.md
# result_tx_reader

Drains completed result rows from the result buffer and serialises each one as a framed byte stream toward the transmit path (UDP/MAC packer). Each frame is a 2-byte row header followed by one row of classifier results. Reads are issued only while a full row is pending in the buffer (`pkt_ready`). The block pulses `rd_row_data_done` once the last byte of a frame has been accepted downstream, which releases the row slot in the buffer.

## Interface
Parameters:
- `PKT_LEN`, 1257: payload bytes per row (window positions per line).
- `ROWS`, 696: rows per frame; row index wraps `ROWS-1 → 0`.
- `ADDR_W`, 13: result RAM address width (depth 2^`ADDR_W`).

Ports:
- `clk` in 1: single clock, shared with the result buffer.
- `rst` in 1: synchronous, active-high reset.
- `pkt_ready` in 1: at least one complete row is held in the result buffer.
- `rd_en` out 1: read strobe to the result RAM.
- `rd_addr` out `ADDR_W`: result RAM read address.
- `rd_data` in 8: RAM output; valid exactly 1 cycle after `rd_en`.
- `rd_row_data_done` out 1: 1-cycle pulse when a row has been fully transmitted.
- `tx_valid` out 1: output byte valid.
- `tx_data` out 8: output byte.
- `tx_sop` out 1: first byte of a frame (header byte 0).
- `tx_eop` out 1: last payload byte of a frame.
- `tx_ready` in 1: downstream accept. A byte transfers when `tx_valid && tx_ready`.

## Operation
- FSM states: IDLE, HDR0, HDR1, PAYLOAD, WAIT_DRAIN.
- IDLE → HDR0 when `pkt_ready=1`.
- HDR0 pushes `{row_idx==0, row_idx[14:8]}`. HDR1 pushes `row_idx[7:0]`. Header bytes come from registers, not RAM.
- PAYLOAD issues `PKT_LEN` reads. Each read with `rd_en=1` uses the current `rd_addr`, then `rd_addr` increments. `rd_addr` wraps naturally `2^ADDR_W-1 → 0`, so rows may straddle the wrap.
- After the last read issue: PAYLOAD → WAIT_DRAIN.
- WAIT_DRAIN → IDLE on acceptance of the `tx_eop` byte. In that same cycle: `rd_row_data_done=1` and `row_idx` advances (wrapping at `ROWS-1`).
- Flow control: a 2-entry output skid buffer holds bytes.
  - A read (or header push) is issued only if `occupancy + reads_in_flight < 2`.
  - Header bytes and RAM bytes never overflow the buffer.
- `tx_sop`/`tx_eop` travel with their byte through the skid buffer as tag bits.
- `rd_addr` persists across frames; it is never reloaded except by reset. It therefore stays aligned with the buffer's write address.
- `pkt_ready` is sampled only in IDLE. Deassertion mid-frame is ignored; the row was already complete.
- `PKT_LEN` payload count uses an 11-bit counter; `row_idx` is 15 bits.

## Timing
- Reset values: `rd_en=0`, `rd_addr=0`, `rd_row_data_done=0`, `tx_valid=0`, `tx_data=0`, `tx_sop=0`, `tx_eop=0`, FSM=IDLE, `row_idx=0`, skid buffer empty.
- Latency from `pkt_ready` rising in IDLE to `tx_valid` with `tx_sop`: 2 cycles (FSM register + skid register).
- First `rd_en`: 2 cycles after leaving IDLE, provided `tx_ready=1`.
- With `tx_ready` held high: 1 byte/cycle. Frame = `PKT_LEN+2` cycles. Minimum gap between frames = 2 idle cycles on `tx_valid`.
- With `tx_ready=0`: at most 2 bytes held. `rd_en` stays low until space frees.
  - `tx_valid`/`tx_data`/tags hold stable while stalled.
- `rd_row_data_done` asserts the same cycle `tx_eop` is accepted, for exactly 1 cycle.
- A simultaneous write-done in the buffer is legal: the buffer nets it to zero change.
- `rst` mid-frame: everything returns to reset values next cycle. No `rd_row_data_done` is generated; the partial frame is abandoned.

## Structure
- Shared package holds:
  - `PKT_LEN`, `ROWS`, `ADDR_W`;
  - header field widths (`ROW_IDX_W=15`, `SOF` bit position);
  - FSM state encoding constants.
- One sub-module: `tx_skid_buf`, a 2-entry valid/ready buffer for 10 bits (data, sop, eop). It exposes `occupancy`.
- Top level holds: FSM, address/row counters, in-flight read tracking, done pulse.

## Test plan
- Reset, then `pkt_ready=1`, `tx_ready=1`, RAM preloaded `addr[7:0]` → frame is `0x80,0x00` then bytes `0x00..` for 1257 bytes; `tx_eop` on byte 1259; one `rd_row_data_done`; `rd_addr=1257` after.
- Random `tx_ready` (50%) over 3 rows → byte stream identical to the no-stall case; never more than 2 bytes buffered; no lost or duplicated bytes.
- 7 rows back-to-back → `rd_addr` crosses 8191→0 in row 7 (starts 7542) with correct data continuity; headers show row indices 0..6, SOF bit only on row 0.
- `ROWS=3`, 4 rows → 4th header is `0x80,0x00`.
- `rst` asserted at payload byte 500 → all outputs 0 next cycle, no done pulse; next frame starts with `rd_addr=0`.
- `pkt_ready` dropped mid-frame → frame completes normally; IDLE is held afterwards until `pkt_ready` returns.
